// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller: the FSM state
// encoding, the default operand width and a helper that sizes the bit
// counter.
// Optional feature macro used by the slice: SERIAL_ADD_SUB_EN (subtract mode).
package serial_add_pkg;

  // Operand/result width used when the top is instantiated without override.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width. The counter only reaches WIDTH-1, but sizing it for
  // WIDTH+1 values keeps WIDTH=1 at a legal one-bit counter.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// full_adder_bit
// Single-bit combinational full adder. This cell is the only arithmetic in
// the serial adder; the controller time-multiplexes it across all bits.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Classic propagate/generate form of the full adder.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial addition controller. Operands are captured on an input
// valid/ready handshake, added LSB first through one full_adder_bit at one
// bit per clock with the carry held in a flop, and the registered result is
// offered on an output valid/ready handshake.
// Configuration macro: SERIAL_ADD_SUB_EN adds an in_sub port; when in_sub is
// captured high the B bits are inverted and the carry starts at 1, giving
// A-B with out_cout=1 meaning no borrow.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake; in_a, in_b operands (WIDTH bits)
//   in_sub             subtract select (only with SERIAL_ADD_SUB_EN)
//   out_valid/out_ready result handshake; out_sum (WIDTH bits), out_cout
//   busy               high while bits are being processed
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic             accept;
  logic             last_bit;
  logic             fa_b;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (cnt_q == LAST_BIT);

  // B is inverted into the adder in subtract mode (two's complement with the
  // carry preset to 1).
`ifdef SERIAL_ADD_SUB_EN
  assign fa_b = b_sr_q[0] ^ sub_q;
`else
  assign fa_b = b_sr_q[0];
`endif

  full_adder_bit u_fa (
    .a    (a_sr_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register plus all datapath flops. Reset aborts any operation in
  // flight and clears the presented result so no partial sum ever escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, leave RUN after the last bit, and
  // return to IDLE once the result has been taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The sum bit enters the MSB of the result register
  // so that after WIDTH shifts bit 0 of the sum sits in bit 0. The visible
  // result registers are only written on the RUN to DONE step.
  always_comb begin
    cnt_d     = cnt_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_sr_d  = res_sr_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d     = sub_q;
`endif
    res_shift = res_sr_q >> 1;
    res_shift[WIDTH-1] = fa_s;

    if (accept) begin
      a_sr_d   = in_a;
      b_sr_d   = in_b;
      res_sr_d = '0;
      cnt_d    = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d    = in_sub;
      carry_d  = in_sub;
`else
      carry_d  = 1'b0;
`endif
    end else if (state_q == RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = res_shift;
      carry_d  = fa_cout;
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = fa_cout;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  // Handshake and status outputs decoded purely from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl: a WIDTH=8 instance driven from a vector
// table plus hand-written backpressure and reset-abort sequences, and a
// WIDTH=1 instance swept over all operand combinations.
// With SERIAL_ADD_SUB_EN defined the table also carries subtract vectors.
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_cout, busy;
  logic [7:0] in_a, in_b, out_sum;
  logic       in_sub_r;

  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
  logic       w1_out_cout, w1_busy;
  logic [0:0] w1_in_a, w1_in_b, w1_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .in_a      (w1_in_a),
    .in_b      (w1_in_b),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (1'b0),
`endif
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_sum   (w1_out_sum),
    .out_cout  (w1_out_cout),
    .busy      (w1_busy)
  );

  // One comparison: count it, and report actual against required on a miss.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operand pair from IDLE (called #1 after an edge), then count
  // edges until out_valid appears, bounded so a stuck DUT cannot hang.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic sub, output int lat);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub_r = sub;
    checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("busy after accept", {31'd0, busy}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  vec_t vecs[$];
  int   lat;

  initial begin
    vecs.push_back('{a: 8'd3,   b: 8'd5,   sub: 1'b0, sum: 8'd8,   cout: 1'b0});
    vecs.push_back('{a: 8'd255, b: 8'd1,   sub: 1'b0, sum: 8'd0,   cout: 1'b1});
    vecs.push_back('{a: 8'd200, b: 8'd100, sub: 1'b0, sum: 8'd44,  cout: 1'b1});
    vecs.push_back('{a: 8'd15,  b: 8'd240, sub: 1'b0, sum: 8'd255, cout: 1'b0});
    vecs.push_back('{a: 8'd128, b: 8'd128, sub: 1'b0, sum: 8'd0,   cout: 1'b1});
    vecs.push_back('{a: 8'd100, b: 8'd100, sub: 1'b0, sum: 8'd200, cout: 1'b0});
    vecs.push_back('{a: 8'd0,   b: 8'd0,   sub: 1'b0, sum: 8'd0,   cout: 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{a: 8'd5,   b: 8'd7,   sub: 1'b1, sum: 8'd254, cout: 1'b0});
    vecs.push_back('{a: 8'd7,   b: 8'd5,   sub: 1'b1, sum: 8'd2,   cout: 1'b1});
    vecs.push_back('{a: 8'd9,   b: 8'd9,   sub: 1'b1, sum: 8'd0,   cout: 1'b1});
`endif

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_sub_r     = 1'b0;
    out_ready    = 1'b1;
    w1_in_valid  = 1'b0;
    w1_in_a      = '0;
    w1_in_b      = '0;
    w1_out_ready = 1'b1;

    // Reset values while reset is held.
    #12;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("reset busy",      {31'd0, busy},      32'd0);
    checkOutput("reset out_sum",   {24'd0, out_sum},   32'd0);
    checkOutput("reset out_cout",  {31'd0, out_cout},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors with out_ready held high: latency WIDTH, DONE one cycle.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, 32'd8);
      checkOutput($sformatf("vec%0d out_sum", i), {24'd0, out_sum}, {24'd0, vecs[i].sum});
      checkOutput($sformatf("vec%0d out_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].cout});
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done one cycle", i), {31'd0, out_valid}, 32'd0);
      checkOutput($sformatf("vec%0d idle again", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held for 5 cycles while new operands wait.
    out_ready = 1'b0;
    applyStimulus(8'd10, 8'd20, 1'b0, lat);
    checkOutput("bp latency", lat, 32'd8);
    in_valid = 1'b1;
    in_a     = 8'd1;
    in_b     = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp%0d out_sum", k), {24'd0, out_sum}, 32'd30);
      checkOutput($sformatf("bp%0d out_cout", k), {31'd0, out_cout}, 32'd0);
      checkOutput($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp after handshake in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp after handshake out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp new op accepted", {31'd0, busy}, 32'd1);
    checkOutput("bp old sum held", {24'd0, out_sum}, 32'd30);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("bp new latency", lat, 32'd8);
    checkOutput("bp new out_sum", {24'd0, out_sum}, 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of RUN, four bits into A=170, B=85.
    in_valid = 1'b1;
    in_a     = 8'd170;
    in_b     = 8'd85;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre-abort busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort busy",      {31'd0, busy},      32'd0);
    checkOutput("abort in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("abort out_sum",   {24'd0, out_sum},   32'd0);
    checkOutput("abort out_cout",  {31'd0, out_cout},  32'd0);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post-abort idle", {31'd0, in_ready}, 32'd1);
    applyStimulus(8'd1, 8'd1, 1'b0, lat);
    checkOutput("post-abort latency", lat, 32'd8);
    checkOutput("post-abort out_sum", {24'd0, out_sum}, 32'd2);
    checkOutput("post-abort out_cout", {31'd0, out_cout}, 32'd0);
    @(posedge clk); #1;

    // WIDTH=1: a single RUN cycle, sum = a^b, carry = a&b.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = i[1:0];
      w1_in_a     = ab[1];
      w1_in_b     = ab[0];
      w1_in_valid = 1'b1;
      checkOutput($sformatf("w1 %0d in_ready", i), {31'd0, w1_in_ready}, 32'd1);
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      checkOutput($sformatf("w1 %0d busy", i), {31'd0, w1_busy}, 32'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("w1 %0d out_valid", i), {31'd0, w1_out_valid}, 32'd1);
      checkOutput($sformatf("w1 %0d out_sum", i), {31'd0, w1_out_sum}, {31'd0, ab[1] ^ ab[0]});
      checkOutput($sformatf("w1 %0d out_cout", i), {31'd0, w1_out_cout}, {31'd0, ab[1] & ab[0]});
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
